// File: rtl/pipe_stage_buf_pkg.sv
// ============================================================================
// pipe_pkg : shared types for the generic inter-stage pipeline buffer
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
// ============================================================================
// pipe_stage_buf_if : handshake/payload bundle around one pipeline stage buffer
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

interface pipe_stage_buf_if #(
  parameter int DATA_W  = 96,
  parameter int NUM_HIT = 2
);

  logic [NUM_HIT-1:0]         hit;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [pipe_pkg::OCC_W-1:0] occupancy;
  logic                       halted;

  // master: the surrounding stages; slave: the buffer itself
  modport master (
    output hit, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, halted
  );

  modport slave (
    input  hit, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, halted
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : generic valid/ready pipeline register with optional skid
//                  entry, hit-qualified advance, flush and sticky halt capture
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 96,
  parameter int NUM_HIT  = 2,
  parameter int SKID_EN  = 1,
  parameter int HALT_EN  = 1,
  parameter int HALT_BIT = 0
) (
  input  wire               CLK,
  input  wire               nRST,
  pipe_stage_buf_if.slave   bus
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;
  logic              halted_q, halted_d;

  logic              en;
  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              pop;
  logic [OCC_W-1:0]  occupancy;

  assign en        = |bus.hit;
  assign out_valid = (state_q != PS_EMPTY);

  // nRST gates in_ready so nothing is offered as acceptable while in reset
  always_comb begin
    in_ready = 1'b0;
    if (SKID_EN != 0)
      in_ready = nRST & (state_q != PS_SKID) & ~halted_q;
    else
      in_ready = nRST & ~halted_q & ((state_q == PS_EMPTY) | bus.out_ready);
  end

  assign accept = bus.in_valid & in_ready & en;
  assign pop    = out_valid & bus.out_ready & en;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    halted_d = halted_q;

    if (bus.flush) begin
      state_d = PS_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (en) begin
      if ((HALT_EN != 0) && accept && bus.in_data[HALT_BIT])
        halted_d = 1'b1;
      case (state_q)
        PS_EMPTY: begin
          if (accept) begin
            state_d = PS_FULL;
            main_d  = bus.in_data;
          end
        end
        PS_FULL: begin
          if (accept && pop) begin
            main_d = bus.in_data;
          end else if (accept && (SKID_EN != 0)) begin
            state_d = PS_SKID;
            skid_d  = bus.in_data;
          end else if (pop) begin
            state_d = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (pop) begin
            state_d = PS_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= PS_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      PS_FULL: occupancy = 2'd1;
      PS_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occupancy;
  assign bus.halted    = (HALT_EN != 0) ? halted_q : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// tb_pipe_stage_buf : directed self-checking bench for pipe_stage_buf
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;

  localparam int DATA_W   = 96;
  localparam int NUM_HIT  = 2;
  localparam int HALT_BIT = 95;

  logic CLK;
  logic nRST;
  int   passed;
  int   total;

  pipe_stage_buf_if #(.DATA_W(DATA_W), .NUM_HIT(NUM_HIT)) bus ();

  pipe_stage_buf #(
    .DATA_W   (DATA_W),
    .NUM_HIT  (NUM_HIT),
    .SKID_EN  (1),
    .HALT_EN  (1),
    .HALT_BIT (HALT_BIT)
  ) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hit       = 2'b00;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #12;
    chk("rst_out_valid", DATA_W'(bus.out_valid), 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_occ",       DATA_W'(bus.occupancy), 0);
    chk("rst_halted",    DATA_W'(bus.halted), 0);
    chk("rst_in_ready",  DATA_W'(bus.in_ready), 0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rel_in_ready",  DATA_W'(bus.in_ready), 1);
    step();
  endtask

  task automatic test_single();
    bus.hit = 2'b01; bus.in_valid = 1'b1; bus.in_data = 'hA5; bus.out_ready = 1'b1;
    step();
    chk("single_valid", DATA_W'(bus.out_valid), 1);
    chk("single_data",  bus.out_data, 'hA5);
    chk("single_occ",   DATA_W'(bus.occupancy), 1);
    bus.in_valid = 1'b0;
    step();
    chk("single_pop_occ",  DATA_W'(bus.occupancy), 0);
    chk("single_pop_hold", bus.out_data, 'hA5);
  endtask

  task automatic test_back_to_back();
    bus.hit = 2'b10; bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DATA_W'(i);
      #1;
      chk("b2b_in_ready", DATA_W'(bus.in_ready), 1);
      step();
      chk("b2b_data", bus.out_data, DATA_W'(i));
      chk("b2b_occ",  DATA_W'(bus.occupancy), 1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("b2b_drain_occ", DATA_W'(bus.occupancy), 0);
  endtask

  task automatic test_stall();
    bus.hit = 2'b01; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 'h11;
    step();
    chk("stall_occ1", DATA_W'(bus.occupancy), 1);
    bus.in_data = 'h22;
    step();
    chk("stall_occ2",   DATA_W'(bus.occupancy), 2);
    chk("stall_ready0", DATA_W'(bus.in_ready), 0);
    chk("stall_head",   bus.out_data, 'h11);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("stall_pop1_occ",  DATA_W'(bus.occupancy), 1);
    chk("stall_pop1_data", bus.out_data, 'h22);
    step();
    chk("stall_pop2_occ",  DATA_W'(bus.occupancy), 0);
  endtask

  task automatic test_hold_en();
    bus.hit = 2'b11; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 'h33; step();
    bus.in_data = 'h44; step();
    chk("hold_fill_occ", DATA_W'(bus.occupancy), 2);
    bus.hit = 2'b00; bus.out_ready = 1'b1; bus.in_data = 'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_occ",  DATA_W'(bus.occupancy), 2);
      chk("hold_data", bus.out_data, 'h33);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_occ",   DATA_W'(bus.occupancy), 0);
    chk("flush_data",  bus.out_data, 0);
    chk("flush_valid", DATA_W'(bus.out_valid), 0);
  endtask

  task automatic test_halt();
    logic [DATA_W-1:0] hd;
    hd = '0; hd[HALT_BIT] = 1'b1; hd[7:0] = 8'h81;
    bus.hit = 2'b01; bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = hd;
    #1;
    chk("halt_pre", DATA_W'(bus.halted), 0);
    step();
    chk("halt_set",    DATA_W'(bus.halted), 1);
    chk("halt_ready0", DATA_W'(bus.in_ready), 0);
    chk("halt_data",   bus.out_data, hd);
    bus.in_data = 'h90;
    step();
    chk("halt_no_accept", DATA_W'(bus.occupancy), 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("halt_drain", DATA_W'(bus.occupancy), 0);
    chk("halt_stays", DATA_W'(bus.halted), 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("halt_flush_keep", DATA_W'(bus.halted), 1);
  endtask

  task automatic test_async_reset();
    nRST = 1'b0;
    #1;
    chk("areset_halted_clr", DATA_W'(bus.halted), 0);
    @(negedge CLK);
    nRST = 1'b1;
    bus.hit = 2'b01; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 'h12; step();
    bus.in_data = 'h34; step();
    chk("areset_fill", DATA_W'(bus.occupancy), 2);
    #2;
    nRST = 1'b0;
    #1;
    chk("areset_occ",   DATA_W'(bus.occupancy), 0);
    chk("areset_valid", DATA_W'(bus.out_valid), 0);
    chk("areset_data",  bus.out_data, 0);
    @(negedge CLK);
    nRST = 1'b1;
    bus.in_data = 'h7;
    step();
    bus.in_valid = 1'b0;
    chk("areset_push_occ",   DATA_W'(bus.occupancy), 1);
    chk("areset_push_data",  bus.out_data, 'h7);
    chk("areset_push_valid", DATA_W'(bus.out_valid), 1);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_hold_en();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed EX/MEM latch: a generic inter-stage pipeline register with valid/ready handshake and an optional 2-entry skid slot.
- Advances only when a hit qualifier fires, with synchronous flush and a sticky halt capture.
- Sits between any two datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the stage's control/data fields are packed into one DATA_W vector by the instantiating stage.

Parameters:
- DATA_W, 96, width of packed stage payload
- NUM_HIT, 2, number of hit qualifiers (e.g. ihit, dhit); stage enable is their OR
- SKID_EN, 1, 1 = second (skid) entry present; 0 = single entry, in_ready combinationally depends on out_ready
- HALT_EN, 1, 1 = sticky halt capture enabled
- HALT_BIT, 0, bit index of in_data that carries the halt flag (0 <= HALT_BIT < DATA_W)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- hit  in  NUM_HIT  stage-advance qualifiers; en = |hit
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream presents payload
- in_ready  out  1  stage can accept payload this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream consumes this cycle
- out_data  out  DATA_W  head entry payload
- occupancy  out  2  live entries: 0, 1 or 2
- halted  out  1  sticky: a halt-flagged entry has been accepted

Behaviour:
- Reset (async, nRST=0): state EMPTY, main and skid registers 0, out_valid=0, out_data=0, occupancy=0, halted=0. in_ready is 0 during reset.
- States: EMPTY (0 entries), FULL (main valid), SKID (main and skid valid; reachable only when SKID_EN=1).
- Derived signals:
  - en = |hit
  - accept = in_valid & in_ready & en
  - pop = out_valid & out_ready & en
- in_ready:
  - SKID_EN=1: in_ready = (state != SKID) & ~halted. Registered-only, no out_ready path.
  - SKID_EN=0: in_ready = ~halted & (state==EMPTY | out_ready).
- Transitions, applied when en=1 and flush=0:
  - EMPTY: accept -> FULL, main<=in_data.
  - FULL, accept & pop -> FULL, main<=in_data (1-cycle throughput).
  - FULL, accept & ~pop -> SKID, skid<=in_data; main unchanged.
  - FULL, ~accept & pop -> EMPTY.
  - FULL, otherwise -> hold.
  - SKID: pop -> FULL, main<=skid; no accept possible. Otherwise hold.
- en=0: every register holds regardless of in_valid/out_ready. No transfer occurs on either side.
- flush=1, priority over en and all transfers:
  - next state EMPTY; main and skid <= 0; out_valid=0.
  - halted is NOT cleared by flush.
  - flush while en=0 still takes effect.
- out_data = main register; out_valid = (state != EMPTY). On a pop to EMPTY, out_data holds its last value (not zeroed).
- occupancy: EMPTY=0, FULL=1, SKID=2.
- halted: set on the cycle after an accept whose in_data[HALT_BIT]=1 (HALT_EN=1). Afterwards in_ready=0 until reset. Entries already held still drain normally. HALT_EN=0 ties halted=0.
- Ordering: entries leave strictly in acceptance order; the skid entry never overtakes main.
- Latency: accepted payload visible on out_data 1 cycle after accept when the stage is empty or popping; otherwise after the preceding entries drain.
- Reset mid-operation: all entries are dropped immediately (async); no partial state survives.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_t {PS_EMPTY, PS_FULL, PS_SKID}
  - localparam OCC_W = 2
- No sub-module required. main/skid are two plain registers in one always_ff plus next-state logic in one always_comb.
- Existing stage latches (EX/MEM etc.) become thin wrappers that pack/unpack fields into DATA_W and instantiate pipe_stage_buf.

Test Plan:
- Reset, then hit=2'b01, in_valid=1, in_data=0xA5, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xA5, occupancy=1.
- Back-to-back stream 1,2,3,4 with hit=2'b10, out_ready=1 every cycle -> out_data 1,2,3,4 on consecutive cycles, in_ready stays 1.
- Stall: hold FULL with 0x11, out_ready=0, push 0x22 -> occupancy=2, in_ready=0. Then out_ready=1 -> out_data 0x11 then 0x22, occupancy 2->1->0.
- hit=0 with in_valid=1 and out_ready=1 for 5 cycles -> no register changes, occupancy constant. flush=1 during hit=0 -> occupancy=0, out_data=0.
- Accept entry with bit HALT_BIT=1 -> halted=1 next cycle, in_ready=0 thereafter. Held entry still pops. flush keeps halted=1. Only nRST clears it.
- Assert nRST=0 while occupancy=2 -> all outputs 0 immediately (without CLK edge). After release, a push of 0x7 appears as sole entry.
